// File: rtl/calc_pkg.sv
// Shared calculator definitions: control states and signed range limits,
// used by the sequential multiplier and the future divide block.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SIGN
  } state_t;

  // Largest positive value of a w-bit two's-complement number.
  function automatic logic signed [63:0] signed_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit two's-complement number.
  function automatic logic signed [63:0] signed_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/twos_neg.sv
// Combinational two's-complement helper: conditionally negates its input
// (abs when i_neg is the input's own sign bit) and reports the input sign.
module twos_neg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  assign o_sign = i_val[WIDTH-1];
  // |-2^(W-1)| wraps back to 2^(W-1), which is exact as an unsigned magnitude.
  assign o_mag  = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/seq_signed_mult.sv
// Sequential shift-add signed multiplier (one magnitude bit per cycle).
// Define MULT_SAT_EN to saturate c on overflow; otherwise c wraps.
module seq_signed_mult
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifdef MULT_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(signed_min(WIDTH));
`endif

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_mag_a;
  logic [WIDTH-1:0]       r_mag_b;
  logic                   r_neg;
  logic [2*WIDTH-1:0]     r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_c;
  logic                   r_ovf;
  logic                   r_done;

  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic                   w_sign_a;
  logic                   w_sign_b;
  logic [WIDTH-1:0]       w_res;
  logic                   w_res_sign;
  logic                   w_ovf;
  logic [WIDTH-1:0]       w_c;

  twos_neg #(.WIDTH(WIDTH)) u_abs_a (
    .i_val (a),
    .i_neg (a[WIDTH-1]),
    .o_mag (w_mag_a),
    .o_sign(w_sign_a)
  );

  twos_neg #(.WIDTH(WIDTH)) u_abs_b (
    .i_val (b),
    .i_neg (b[WIDTH-1]),
    .o_mag (w_mag_b),
    .o_sign(w_sign_b)
  );

  twos_neg #(.WIDTH(WIDTH)) u_res (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg),
    .o_mag (w_res),
    .o_sign(w_res_sign)
  );

  // Magnitude limit is 2^(W-1)-1 when positive and 2^(W-1) when negative:
  // any high-half bit overflows; bit W-1 overflows unless negative and the rest is zero.
  assign w_ovf = (|r_acc[2*WIDTH-1:WIDTH]) |
                 (w_res_sign & (~r_neg | (|r_acc[WIDTH-2:0])));

`ifdef MULT_SAT_EN
  assign w_c = w_ovf ? (r_neg ? SAT_NEG : SAT_POS) : w_res;
`else
  assign w_c = w_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (r_cnt == LAST_CNT) w_next = SIGN;
      SIGN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand magnitudes and product sign carry no state needing reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_neg   <= w_sign_a ^ w_sign_b;
    end else if (r_state == ACCUM) begin
      r_mag_b <= r_mag_b >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ACCUM: begin
          r_acc <= (r_acc >> 1) +
                   (r_mag_b[0] ? ({{WIDTH{1'b0}}, r_mag_a} << (WIDTH - 1)) : '0);
          r_cnt <= r_cnt + 1'b1;
        end
        SIGN: begin
          r_c    <= w_c;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign c    = r_c;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Self-checking bench for seq_signed_mult (WIDTH=8): directed corners,
// random operands against an integer-arithmetic model, handshake and reset cases.
module tb_seq_signed_mult;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_signed_mult #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c),
    .ovf  (ovf)
  );

  // Reference: true signed product, range-checked, then wrapped or saturated.
  function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                output logic [W-1:0] ec, output logic eo);
    int p;
    p  = int'($signed(ai)) * int'($signed(bi));
    eo = (p > 127) || (p < -128);
    ec = p[W-1:0];
`ifdef MULT_SAT_EN
    if (eo) ec = (p > 0) ? 8'h7F : 8'h80;
`endif
  endfunction

  // Drives one start pulse, scrambles operands afterwards, waits for done.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        output logic [W-1:0] oc, output logic ov,
                        output int lat, output int nb);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    oc = '0; ov = 1'b0; lat = -1; nb = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (busy) nb++;
      @(posedge clk); #1;
      if (done) begin lat = k; oc = c; ov = ovf; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL reset_c got %h want 00", c); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [10] = '{8'h07, 8'hF0, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h80, 8'h40, 8'hF8, 8'h81};
    logic [W-1:0] tb [10] = '{8'hFD, 8'h08, 8'hFF, 8'hFB, 8'h7F, 8'hFF, 8'h80, 8'h02, 8'h10, 8'h02};
    logic [W-1:0] tw [10] = '{8'hEB, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h02};
    logic [W-1:0] ts [10] = '{8'hEB, 8'h80, 8'h7F, 8'h00, 8'h7F, 8'h01, 8'h7F, 8'h7F, 8'h80, 8'h80};
    logic         to [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] oc, ec;
    logic         ov;
    int           lat, nb;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], oc, ov, lat, nb);
`ifdef MULT_SAT_EN
      ec = ts[i];
`else
      ec = tw[i];
`endif
      checks++; if (lat !== 9) begin errors++; $display("FAIL dir_latency[%0d] got %0d want 9", i, lat); end
      checks++; if (oc !== ec) begin errors++; $display("FAIL dir_c[%0d] got %h want %h", i, oc, ec); end
      checks++; if (ov !== to[i]) begin errors++; $display("FAIL dir_ovf[%0d] got %b want %b", i, ov, to[i]); end
      if (i == 0) begin
        checks++; if (nb !== 9) begin errors++; $display("FAIL dir_busy_cycles got %0d want 9", nb); end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ai, bi, oc, ec;
    logic         ov, eo;
    int           lat, nb;
    for (int i = 0; i < 40; i++) begin
      ai = W'($urandom); bi = W'($urandom);
      if (i % 8 == 0) ai = 8'h80;
      run_op(ai, bi, oc, ov, lat, nb);
      model(ai, bi, ec, eo);
      checks++; if (lat !== 9) begin errors++; $display("FAIL rnd_latency a=%h b=%h got %0d want 9", ai, bi, lat); end
      checks++; if (oc !== ec) begin errors++; $display("FAIL rnd_c a=%h b=%h got %h want %h", ai, bi, oc, ec); end
      checks++; if (ov !== eo) begin errors++; $display("FAIL rnd_ovf a=%h b=%h got %b want %b", ai, bi, ov, eo); end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] oc, ec;
    logic         ov, eo;
    int           lat, nd;
    @(negedge clk);
    a = 8'd13; b = 8'hF9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    oc = '0; ov = 1'b0; lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 4) begin a = 8'h55; b = 8'h22; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = k; oc = c; ov = ovf; end
    end
    start = 1'b0;
    model(8'd13, 8'hF9, ec, eo);
    checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency got %0d want 9", lat); end
    checks++; if (oc !== ec) begin errors++; $display("FAIL ign_c got %h want %h", oc, ec); end
    checks++; if (ov !== eo) begin errors++; $display("FAIL ign_ovf got %b want %b", ov, eo); end
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL ign_extra_done got %0d pulses want 0", nd); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oc1, oc2, ec1, ec2;
    logic         ov1, ov2, eo1, eo2;
    int           lat1, lat2, nb;
    run_op(8'h19, 8'h05, oc1, ov1, lat1, nb);
    run_op(8'hE7, 8'h06, oc2, ov2, lat2, nb);
    model(8'h19, 8'h05, ec1, eo1);
    model(8'hE7, 8'h06, ec2, eo2);
    checks++; if (oc1 !== ec1 || ov1 !== eo1) begin errors++; $display("FAIL b2b_first got c=%h ovf=%b want c=%h ovf=%b", oc1, ov1, ec1, eo1); end
    checks++; if (lat2 !== 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat2); end
    checks++; if (oc2 !== ec2 || ov2 !== eo2) begin errors++; $display("FAIL b2b_second got c=%h ovf=%b want c=%h ovf=%b", oc2, ov2, ec2, eo2); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b want 0", done); end
    checks++; if (c !== ec2) begin errors++; $display("FAIL b2b_c_held got %h want %h", c, ec2); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] oc, ec;
    logic         ov, eo;
    int           lat, nb, nd;
    @(negedge clk);
    a = 8'h0B; b = 8'h09; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL abort_c got %h want 00", c); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", ovf); end
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", nd); end
    run_op(8'hF5, 8'h0C, oc, ov, lat, nb);
    model(8'hF5, 8'h0C, ec, eo);
    checks++; if (lat !== 9) begin errors++; $display("FAIL abort_next_latency got %0d want 9", lat); end
    checks++; if (oc !== ec) begin errors++; $display("FAIL abort_next_c got %h want %h", oc, ec); end
    checks++; if (ov !== eo) begin errors++; $display("FAIL abort_next_ovf got %b want %b", ov, eo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
